div_result_display: RTL
=======================

Name: div_result_display

Overview:
- Downstream consumer of the 4-bit divider's quotient/remainder.
- Captures a result on a load strobe and splits each value into decimal tens/units.
- Time-multiplexes four 7-segment digits on the lab board: quotient on digits 3..2, remainder on 1..0.
- Shows a dedicated divide-by-zero pattern and a "no data yet" pattern.

Parameters:
- SCAN_DIV, default 50000: clk cycles each digit is lit (legal ≥ 2); bench uses 4.
- BLANK_LZ, default 1: 1 = blank a tens digit whose value is 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  one-cycle strobe; capture the data inputs this cycle.
- quotient  input  4  unsigned divider quotient.
- remainder  input  4  unsigned divider remainder.
- div_by_zero  input  1  divider saw denominator = 0; sampled with load.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- an  output  4  digit enables, active-low one-hot, registered; an[0] = rightmost.
- data_valid  output  1  high once any load has been captured since reset.

Behaviour:
- Reset (sync, rst high at a rising edge):
  - Capture regs cleared; data_valid = 0.
  - Prescaler = 0; digit index = 0.
  - seg = 7'b1111111; an = 4'b1111 (all dark).
  - rst overrides load and scan in the same cycle; reset mid-scan restarts the scan at index 0.
- Capture:
  - load=1 at edge N: q_r, r_r, dz_r and data_valid=1 update at edge N.
  - Display uses the new data from edge N+1 onward, i.e. 1-cycle latency to seg.
  - Back-to-back loads: the last one wins.
  - A load coinciding with a digit change: the digit change takes effect and the new digit shows the new data.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - At terminal count, index advances 0→1→2→3→0.
  - an/seg are registered from the index and data of the previous cycle. After reset release, the first edge drives index 0 (an = 4'b1110).
- Digit content (idx3, idx2, idx1, idx0):
  - data_valid=0: dash on all four, seg = 7'b0111111.
  - dz_r=1: E, r, r, blank. E = 7'b0000110; r = 7'b0101111; blank = 7'b1111111.
  - Normal: q tens, q units, r tens, r units.
  - Tens = (v ≥ 10); units = v − 10·tens.
  - Tens digit 0 is blank if BLANK_LZ=1, else '0'.
- Decimal encodings (active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- Inputs are valid only on load; they are ignored otherwise.
- No other outputs; no handshake back to the divider.

Decomposition:
- Package div_disp_pkg holds:
  - typedef seg_t (logic [6:0]) and typedef digit_idx_t (logic [1:0]).
  - Constants SEG_BLANK, SEG_DASH, SEG_E, SEG_R.
  - Function bin4_to_bcd returning {tens, units}.
- One sub-module, seg7_decoder: combinational, 4-bit digit + blank flag → seg_t, instantiated once on the muxed digit.
- Prescaler, index, capture and output registers live in the top.

Test Plan (SCAN_DIV=4, BLANK_LZ=1):
- Reset held 3 cycles, then released → while rst: an=1111, seg=1111111, data_valid=0; after: an cycles 1110,1101,1011,0111 every 4 clk, seg=0111111 on each.
- load with q=2, r=1, dz=0 (13/6) → data_valid=1 next edge; scan shows an=1110 seg=1111001, an=1101 blank, an=1011 seg=0100100, an=0111 blank.
- load with q=15, r=12 → idx3 '1'(1111001), idx2 '5'(0010010), idx1 '1', idx0 '2'(0100100). Repeat with BLANK_LZ=0 and q=3, r=0 → idx3 '0'(1000000).
- load with dz=1 (q, r arbitrary) → idx3 0000110, idx2 0101111, idx1 0101111, idx0 1111111. A following dz=0 load restores numeric digits.
- load asserted on two consecutive cycles (q=4, then q=9) and once exactly on a prescaler terminal count → only q=9 is displayed; the newly lit digit shows the new value with 1-cycle latency.
- rst pulsed 1 cycle mid-scan at index 2 → next edge an=1111, data_valid=0; scan restarts at index 0 showing dashes.

Source files
------------

// File: rtl/div_disp_pkg.sv
// Shared types, segment patterns and binary-to-BCD helper for the divider result display.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package div_disp_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [1:0] digit_idx_t;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_DASH  = 7'b0111111;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_R     = 7'b0101111;

  // A 4-bit value never exceeds 15, so the tens digit is at most 1.
  function automatic logic [7:0] bin4_to_bcd(input logic [3:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    if (v >= 4'd10) begin
      tens  = 4'd1;
      units = v - 4'd10;
    end else begin
      tens  = 4'd0;
      units = v;
    end
    return {tens, units};
  endfunction

endpackage

// File: rtl/div_result_display_seg7_decoder.sv
// Combinational decimal digit to active-low 7-segment pattern.
// Non-decimal codes and the blank flag both produce a dark digit.
module seg7_decoder
  import div_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = 7'b1000000;
        4'd1:    seg = 7'b1111001;
        4'd2:    seg = 7'b0100100;
        4'd3:    seg = 7'b0110000;
        4'd4:    seg = 7'b0011001;
        4'd5:    seg = 7'b0010010;
        4'd6:    seg = 7'b0000010;
        4'd7:    seg = 7'b1111000;
        4'd8:    seg = 7'b0000000;
        4'd9:    seg = 7'b0010000;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/div_result_display.sv
// Captures a divider quotient/remainder on load and scans it onto four multiplexed 7-segment digits.
// Quotient on digits 3..2, remainder on 1..0; dashes before first load, "Err" on divide-by-zero.
module div_result_display
  import div_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] quotient,
  input  logic [3:0] remainder,
  input  logic       div_by_zero,
  output seg_t       seg,
  output logic [3:0] an,
  output logic       data_valid
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(SCAN_DIV - 1);

  logic [3:0]  q_r;
  logic [3:0]  r_r;
  logic        dz_r;
  logic [CW-1:0] cnt;
  digit_idx_t  idx;

  logic [7:0]  bcd_q;
  logic [7:0]  bcd_r;
  logic [3:0]  digit;
  logic        digit_blank;
  logic        use_special;
  seg_t        special_seg;
  seg_t        dec_seg;
  seg_t        seg_next;

  assign bcd_q = bin4_to_bcd(q_r);
  assign bcd_r = bin4_to_bcd(r_r);

  // Digit content selection from the currently scanned index and captured data.
  always_comb begin
    digit       = 4'd0;
    digit_blank = 1'b0;
    use_special = 1'b0;
    special_seg = SEG_BLANK;
    if (!data_valid) begin
      use_special = 1'b1;
      special_seg = SEG_DASH;
    end else if (dz_r) begin
      use_special = 1'b1;
      case (idx)
        2'd3:    special_seg = SEG_E;
        2'd2:    special_seg = SEG_R;
        2'd1:    special_seg = SEG_R;
        default: special_seg = SEG_BLANK;
      endcase
    end else begin
      case (idx)
        2'd3: begin
          digit       = bcd_q[7:4];
          digit_blank = BLANK_LZ && (bcd_q[7:4] == 4'd0);
        end
        2'd2:    digit = bcd_q[3:0];
        2'd1: begin
          digit       = bcd_r[7:4];
          digit_blank = BLANK_LZ && (bcd_r[7:4] == 4'd0);
        end
        default: digit = bcd_r[3:0];
      endcase
    end
  end

  seg7_decoder u_dec (
    .digit (digit),
    .blank (digit_blank),
    .seg   (dec_seg)
  );

  assign seg_next = use_special ? special_seg : dec_seg;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r        <= 4'd0;
      r_r        <= 4'd0;
      dz_r       <= 1'b0;
      data_valid <= 1'b0;
      cnt        <= '0;
      idx        <= 2'd0;
      seg        <= SEG_BLANK;
      an         <= 4'b1111;
    end else begin
      if (load) begin
        q_r        <= quotient;
        r_r        <= remainder;
        dz_r       <= div_by_zero;
        data_valid <= 1'b1;
      end
      if (cnt == TC) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // Outputs reflect the index and data held before this edge.
      seg <= seg_next;
      an  <= ~(4'b0001 << idx);
    end
  end

endmodule
